// File: rtl/psola_ola_engine.sv
// PSOLA overlap-add engine: double-buffered frame capture, triangular-window grain
// relocation from period tau to target_tau, and saturated playback one frame behind.
module psola_ola_engine #(
    parameter int WINDOW_SIZE  = 2048,
    parameter int SAMPLE_WIDTH = 16,
    parameter int FRAC_WIDTH   = 10,
    parameter int TAU_WIDTH    = 11
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic [SAMPLE_WIDTH-1:0] sample_in,
    input  logic                    sample_valid_in,
    input  logic [TAU_WIDTH-1:0]    tau_in,
    input  logic [TAU_WIDTH-1:0]    target_tau_in,
    input  logic                    tau_valid_in,
    input  logic                    bypass_in,
    output logic [SAMPLE_WIDTH-1:0] autotuned_out,
    output logic                    autotuned_valid_out,
    output logic                    busy_out,
    output logic                    overrun_out
);
    localparam int AW    = $clog2(WINDOW_SIZE);
    localparam int ACC_W = SAMPLE_WIDTH + 2;
    localparam int PW    = ((AW > TAU_WIDTH) ? AW : TAU_WIDTH) + 2;
    localparam int WW    = FRAC_WIDTH + 1;
    localparam int MW    = PW + WW;
    localparam int PRW   = SAMPLE_WIDTH + WW + 1;
    localparam int CW    = ((AW + 1) > ($clog2(FRAC_WIDTH + 1) + 1)) ? (AW + 1) : ($clog2(FRAC_WIDTH + 1) + 1);
    localparam logic [PW-1:0] WIN   = PW'(WINDOW_SIZE);
    localparam logic [WW-1:0] W_ONE = {1'b1, {FRAC_WIDTH{1'b0}}};

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DIVIDE = 3'd1;
    localparam logic [2:0] S_CLEAR  = 3'd2;
    localparam logic [2:0] S_READ   = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;
    localparam logic [2:0] S_CALC   = 3'd5;
    localparam logic [2:0] S_WRITE  = 3'd6;
    localparam logic [2:0] S_COPY   = 3'd7;

    function automatic logic [ACC_W-1:0] sat_acc(input logic [ACC_W:0] v);
        if (v[ACC_W] == v[ACC_W-1]) return v[ACC_W-1:0];
        else if (v[ACC_W]) return {1'b1, {(ACC_W-1){1'b0}}};
        else return {1'b0, {(ACC_W-1){1'b1}}};
    endfunction

    function automatic logic [SAMPLE_WIDTH-1:0] sat_out(input logic [ACC_W-1:0] v);
        if ((&v[ACC_W-1:SAMPLE_WIDTH-1]) || !(|v[ACC_W-1:SAMPLE_WIDTH-1])) return v[SAMPLE_WIDTH-1:0];
        else if (v[ACC_W-1]) return {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};
        else return {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
    endfunction

    function automatic logic grain_ok(input logic [PW-1:0] a, input logic [PW-1:0] s, input logic [PW-1:0] tt);
        return ((a + tt) <= WIN) && (s < WIN);
    endfunction

    logic [SAMPLE_WIDTH-1:0] in_mem  [2*WINDOW_SIZE];
    logic [ACC_W-1:0]        acc_mem [2*WINDOW_SIZE];
    logic [SAMPLE_WIDTH-1:0] x_rd_q;
    logic [ACC_W-1:0]        acc_rd_q, play_rd_q;

    logic [2:0]              state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [AW-1:0]           sample_count_q, sample_count_d;
    logic                    in_sel_q, in_sel_d, out_sel_q, out_sel_d;
    logic [TAU_WIDTH-1:0]    tau_lat_q, tau_lat_d, tgt_lat_q, tgt_lat_d;
    logic                    tau_seen_q, tau_seen_d, byp_lat_q, byp_lat_d;
    logic [TAU_WIDTH-1:0]    ftau_q, ftau_d, ftgt_q, ftgt_d;
    logic [WW-1:0]           recip_q, recip_d;
    logic [TAU_WIDTH-1:0]    rem_q, rem_d;
    logic [PW-1:0]           a_q, a_d, s_q, s_d, o_q, o_d;
    logic [ACC_W-1:0]        sum_q, sum_d;
    logic                    play_v1_q, play_v1_d;
    logic [SAMPLE_WIDTH-1:0] out_q, out_d;
    logic                    out_v_q, out_v_d, busy_q, busy_d, ovr_q, ovr_d;

    logic                    boundary, frame_bypass, sample_we, acc_we;
    logic [AW:0]             acc_wa;
    logic [ACC_W-1:0]        acc_wd, contrib;
    logic [TAU_WIDTH-1:0]    tau_now, tgt_now;
    logic [PW-1:0]           two_tau, xa_sum, so_sum, mult_o;
    logic [AW-1:0]           x_idx;
    logic [TAU_WIDTH:0]      rem_sh;
    logic [MW-1:0]           wprod;
    logic [WW-1:0]           w;
    logic signed [PRW-1:0]   prod;

    // Frame-level decode, window weight and weighted-sample product.
    always_comb begin
        sample_we    = sample_valid_in && !rst_in;
        boundary     = sample_valid_in && (sample_count_q == AW'(WINDOW_SIZE - 1));
        tau_now      = tau_valid_in ? tau_in : tau_lat_q;
        tgt_now      = tau_valid_in ? target_tau_in : tgt_lat_q;
        frame_bypass = byp_lat_q || bypass_in || (tau_now < TAU_WIDTH'(2)) ||
                       !(tau_seen_q || tau_valid_in) || ((PW'(tau_now) << 1) > WIN);
        two_tau      = PW'(ftau_q) << 1;
        xa_sum       = a_q + o_q;
        so_sum       = s_q + o_q;
        x_idx        = (state_q == S_COPY) ? AW'(cnt_q) : AW'(xa_sum);
        rem_sh       = {rem_q, (cnt_q == {CW{1'b0}})};
        mult_o       = (o_q < PW'(ftau_q)) ? o_q : (two_tau - o_q);
        wprod        = MW'(mult_o) * MW'(recip_q);
        w            = (wprod > MW'(W_ONE)) ? W_ONE : WW'(wprod);
        prod         = PRW'($signed(x_rd_q)) * PRW'($signed({1'b0, w}));
        contrib      = ACC_W'(prod >>> FRAC_WIDTH);
    end

    // Next-state logic: tau latch, playback pipeline and processing FSM.
    always_comb begin
        state_d = state_q;  cnt_d = cnt_q;  in_sel_d = in_sel_q;  out_sel_d = out_sel_q;
        ftau_d = ftau_q;  ftgt_d = ftgt_q;  recip_d = recip_q;  rem_d = rem_q;
        a_d = a_q;  s_d = s_q;  o_d = o_q;  sum_d = sum_q;  ovr_d = 1'b0;
        acc_we = 1'b0;  acc_wa = {out_sel_q, AW'(so_sum)};  acc_wd = sum_q;
        sample_count_d = sample_valid_in ? (sample_count_q + AW'(1)) : sample_count_q;
        play_v1_d = sample_valid_in;
        out_v_d   = play_v1_q;
        out_d     = play_v1_q ? sat_out(play_rd_q) : out_q;
        if (tau_valid_in) begin
            tau_lat_d = tau_in;  tgt_lat_d = target_tau_in;  tau_seen_d = 1'b1;
        end else begin
            tau_lat_d = tau_lat_q;  tgt_lat_d = tgt_lat_q;  tau_seen_d = tau_seen_q;
        end
        byp_lat_d = byp_lat_q || bypass_in;

        case (state_q)
            S_IDLE: state_d = S_IDLE;
            S_DIVIDE: begin
                if (rem_sh >= {1'b0, ftau_q}) begin
                    rem_d   = TAU_WIDTH'(rem_sh - {1'b0, ftau_q});
                    recip_d = {recip_q[WW-2:0], 1'b1};
                end else begin
                    rem_d   = TAU_WIDTH'(rem_sh);
                    recip_d = {recip_q[WW-2:0], 1'b0};
                end
                if (cnt_q == CW'(FRAC_WIDTH)) begin
                    state_d = S_CLEAR;  cnt_d = {CW{1'b0}};
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_CLEAR: begin
                acc_we = 1'b1;  acc_wa = {out_sel_q, AW'(cnt_q)};  acc_wd = {ACC_W{1'b0}};
                if (cnt_q == CW'(WINDOW_SIZE - 1)) state_d = S_READ;
                else cnt_d = cnt_q + CW'(1);
            end
            S_READ:  state_d = S_WAIT;
            S_WAIT:  state_d = S_CALC;
            S_CALC: begin
                sum_d   = sat_acc({acc_rd_q[ACC_W-1], acc_rd_q} + {contrib[ACC_W-1], contrib});
                state_d = S_WRITE;
            end
            S_WRITE: begin
                acc_we = (so_sum < WIN);
                if ((o_q + PW'(1)) == two_tau) begin
                    o_d = {PW{1'b0}};  a_d = a_q + PW'(ftau_q);  s_d = s_q + PW'(ftgt_q);
                    state_d = grain_ok(a_q + PW'(ftau_q), s_q + PW'(ftgt_q), two_tau) ? S_READ : S_IDLE;
                end else begin
                    o_d = o_q + PW'(1);  state_d = S_READ;
                end
            end
            S_COPY: begin
                // x_rd_q trails the copy index by one cycle, so write the previous entry.
                acc_we = (cnt_q != {CW{1'b0}});
                acc_wa = {out_sel_q, AW'(cnt_q - CW'(1))};
                acc_wd = ACC_W'($signed(x_rd_q));
                if (cnt_q == CW'(WINDOW_SIZE)) state_d = S_IDLE;
                else cnt_d = cnt_q + CW'(1);
            end
            default: state_d = S_IDLE;
        endcase

        if (boundary) begin
            in_sel_d = !in_sel_q;  out_sel_d = !out_sel_q;
            ftau_d = tau_now;  ftgt_d = (tgt_now == {TAU_WIDTH{1'b0}}) ? tau_now : tgt_now;
            byp_lat_d = 1'b0;  ovr_d = (state_q != S_IDLE);
            state_d = frame_bypass ? S_COPY : S_DIVIDE;
            cnt_d = {CW{1'b0}};  rem_d = {TAU_WIDTH{1'b0}};  recip_d = {WW{1'b0}};
            a_d = {PW{1'b0}};  s_d = {PW{1'b0}};  o_d = {PW{1'b0}};
        end else begin
            ovr_d = 1'b0;
        end
        busy_d = (state_d != S_IDLE);
    end

    // Frame buffers with registered read ports.
    always_ff @(posedge clk_in) begin
        if (sample_we) in_mem[{in_sel_q, sample_count_q}] <= sample_in;
        if (acc_we) acc_mem[acc_wa] <= acc_wd;
        x_rd_q    <= in_mem[{!in_sel_q, x_idx}];
        acc_rd_q  <= acc_mem[{out_sel_q, AW'(so_sum)}];
        play_rd_q <= acc_mem[{!out_sel_q, sample_count_q}];
    end

    // State and output registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= S_IDLE;  cnt_q <= {CW{1'b0}};  sample_count_q <= {AW{1'b0}};
            in_sel_q <= 1'b0;  out_sel_q <= 1'b0;
            tau_lat_q <= {TAU_WIDTH{1'b0}};  tgt_lat_q <= {TAU_WIDTH{1'b0}};
            tau_seen_q <= 1'b0;  byp_lat_q <= 1'b0;
            ftau_q <= {TAU_WIDTH{1'b0}};  ftgt_q <= {TAU_WIDTH{1'b0}};
            recip_q <= {WW{1'b0}};  rem_q <= {TAU_WIDTH{1'b0}};
            a_q <= {PW{1'b0}};  s_q <= {PW{1'b0}};  o_q <= {PW{1'b0}};  sum_q <= {ACC_W{1'b0}};
            play_v1_q <= 1'b0;  out_q <= {SAMPLE_WIDTH{1'b0}};
            out_v_q <= 1'b0;  busy_q <= 1'b0;  ovr_q <= 1'b0;
        end else begin
            state_q <= state_d;  cnt_q <= cnt_d;  sample_count_q <= sample_count_d;
            in_sel_q <= in_sel_d;  out_sel_q <= out_sel_d;
            tau_lat_q <= tau_lat_d;  tgt_lat_q <= tgt_lat_d;
            tau_seen_q <= tau_seen_d;  byp_lat_q <= byp_lat_d;
            ftau_q <= ftau_d;  ftgt_q <= ftgt_d;  recip_q <= recip_d;  rem_q <= rem_d;
            a_q <= a_d;  s_q <= s_d;  o_q <= o_d;  sum_q <= sum_d;
            play_v1_q <= play_v1_d;  out_q <= out_d;
            out_v_q <= out_v_d;  busy_q <= busy_d;  ovr_q <= ovr_d;
        end
    end

    assign autotuned_out       = out_q;
    assign autotuned_valid_out = out_v_q;
    assign busy_out            = busy_q;
    assign overrun_out         = ovr_q;
endmodule

// File: tb/tb_psola_ola_engine.sv
// Scoreboard bench for psola_ola_engine at WINDOW_SIZE=16: stimulus pushes expected
// samples and due cycles; a negedge monitor pops and compares each valid output.
module tb_psola_ola_engine;
    localparam int WS = 16;
    localparam int SW = 16;
    localparam int TW = 11;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b1;
    logic [SW-1:0] sample_in = '0;
    logic          sample_valid_in = 1'b0;
    logic [TW-1:0] tau_in = '0;
    logic [TW-1:0] target_tau_in = '0;
    logic          tau_valid_in = 1'b0;
    logic          bypass_in = 1'b0;
    logic [SW-1:0] autotuned_out;
    logic          autotuned_valid_out;
    logic          busy_out;
    logic          overrun_out;

    psola_ola_engine #(.WINDOW_SIZE(WS), .SAMPLE_WIDTH(SW), .FRAC_WIDTH(10), .TAU_WIDTH(TW)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .sample_in(sample_in), .sample_valid_in(sample_valid_in),
        .tau_in(tau_in), .target_tau_in(target_tau_in), .tau_valid_in(tau_valid_in),
        .bypass_in(bypass_in), .autotuned_out(autotuned_out),
        .autotuned_valid_out(autotuned_valid_out), .busy_out(busy_out), .overrun_out(overrun_out)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    int tests_run = 0;
    int tests_failed = 0;
    int exp_q[$];
    int due_q[$];
    bit dc_q[$];
    int ovr_cnt = 0;
    int mon_e, mon_t;
    bit mon_d;

    // Hand-computed OLA results for constant input, tau=4 (recip=256).
    int ID_T[16]  = '{0, 250, 500, 750, 1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000, 750, 500, 250};
    int SH_T[16]  = '{0, 250, 500, 1000, 1500, 1750, 2000, 1750, 1500, 1000, 500, 250, 0, 0, 0, 0};
    int SAT_T[16] = '{0, 8191, 16383, 32766, 32767, 32767, 32767, 32767, 32767, 32766, 16383, 8191, 0, 0, 0, 0};

    function automatic void check(string name, int act, int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    always @(negedge clk_in) begin
        if (!rst_in) begin
            if (overrun_out) begin
                ovr_cnt++;
                check("busy_after_overrun", int'(busy_out), 1);
            end
            if (autotuned_valid_out) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    mon_t = due_q.pop_front();
                    mon_d = dc_q.pop_front();
                    check("valid_latency", cyc, mon_t);
                    if (!mon_d) check("sample_value", int'($signed(autotuned_out)), mon_e);
                end
            end
        end
    end

    task automatic do_reset(input bit hold_strobe);
        @(negedge clk_in);
        rst_in = 1'b1;  sample_valid_in = hold_strobe;  tau_valid_in = hold_strobe;
        tau_in = TW'(4);  target_tau_in = TW'(4);  bypass_in = 1'b0;
        repeat (3) @(negedge clk_in);
        rst_in = 1'b0;  sample_valid_in = 1'b0;  tau_valid_in = 1'b0;
        exp_q.delete();  due_q.delete();  dc_q.delete();  ovr_cnt = 0;
    endtask

    task automatic latch_tau(input int tau, input int tgt);
        @(negedge clk_in);
        tau_in = TW'(tau);  target_tau_in = TW'(tgt);  tau_valid_in = 1'b1;
        @(negedge clk_in);
        tau_valid_in = 1'b0;
    endtask

    // mode: 0 ramp delayed two frames, 1 identity, 2 shift, 3 saturation,
    // 4 all don't-care, 5 frame 2 constant 1000 then identity.
    task automatic play(input int nfr, input int src, input int cval, input int mode,
                        input int fast_frame, input int tvb_frame, input int tvb_tau, input int tvb_tgt);
        int v, ev, gap;
        for (int f = 0; f < nfr; f++) begin
            for (int n = 0; n < WS; n++) begin
                v = (src == 0) ? (100 * f + n) : cval;
                case (mode)
                    0: ev = 100 * (f - 2) + n;
                    1: ev = ID_T[n];
                    2: ev = SH_T[n];
                    3: ev = SAT_T[n];
                    5: ev = (f == 2) ? 1000 : ID_T[n];
                    default: ev = 0;
                endcase
                gap = (f == fast_frame) ? 4 : 16;
                @(negedge clk_in);
                sample_in = SW'(v);  sample_valid_in = 1'b1;
                if (f == tvb_frame && n == WS - 1) begin
                    tau_in = TW'(tvb_tau);  target_tau_in = TW'(tvb_tgt);  tau_valid_in = 1'b1;
                end
                exp_q.push_back(ev);  due_q.push_back(cyc + 2);  dc_q.push_back((f < 2) || (mode == 4));
                @(negedge clk_in);
                sample_valid_in = 1'b0;  tau_valid_in = 1'b0;
                repeat (gap - 2) @(negedge clk_in);
            end
        end
        repeat (20) @(negedge clk_in);
        check("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        // Strobes held through reset must not leave any trace.
        do_reset(1'b1);
        check("reset_out", int'(autotuned_out), 0);
        check("reset_valid", int'(autotuned_valid_out), 0);
        check("reset_busy", int'(busy_out), 0);
        check("reset_overrun", int'(overrun_out), 0);

        do_reset(1'b0);
        bypass_in = 1'b1;
        play(4, 0, 0, 0, -1, -1, 0, 0);
        check("bypass_no_overrun", ovr_cnt, 0);

        do_reset(1'b0);
        latch_tau(4, 4);
        play(3, 1, 1000, 1, -1, -1, 0, 0);
        check("identity_no_overrun", ovr_cnt, 0);

        do_reset(1'b0);
        latch_tau(4, 2);
        play(3, 1, 1000, 2, -1, -1, 0, 0);

        do_reset(1'b0);
        latch_tau(4, 0);
        play(3, 1, 1000, 1, -1, -1, 0, 0);

        do_reset(1'b0);
        latch_tau(4, 2);
        play(3, 1, 32767, 3, -1, -1, 0, 0);

        do_reset(1'b0);
        latch_tau(1, 1);
        play(3, 0, 0, 0, -1, -1, 0, 0);

        // tau=9 frame is copied through; tau=4 arriving on frame 1's last strobe applies to frame 1.
        do_reset(1'b0);
        latch_tau(9, 9);
        play(4, 1, 1000, 5, -1, 1, 4, 4);

        // Frame 1 is strobed every 4 cycles so frame 0's processing is still running at its end.
        do_reset(1'b0);
        latch_tau(4, 4);
        play(3, 1, 1000, 4, 1, -1, 0, 0);
        check("overrun_pulses", ovr_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
